// File: rtl/game_round_sequencer_if.sv
// Signal bundle between the round sequencer and the surrounding game blocks
// (buttons, comparator, timer, generator, display driver).
interface game_round_sequencer_if;
  logic       start_btn;
  logic       guess_btn;
  logic       match;
  logic       timer_end;
  logic       gen_enable;
  logic       time_load;
  logic [4:0] time_value;
  logic [1:0] state;
  logic       result_ok;
  logic [7:0] level;
  logic [7:0] score;
  logic [2:0] lives;

  modport master (
    input  start_btn, guess_btn, match, timer_end,
    output gen_enable, time_load, time_value, state, result_ok, level, score, lives
  );

  modport slave (
    output start_btn, guess_btn, match, timer_end,
    input  gen_enable, time_load, time_value, state, result_ok, level, score, lives
  );
endinterface

// File: rtl/game_round_sequencer.sv
// Round controller for the binary number game: runs generate/play/feedback
// rounds and keeps score, level and lives.
module game_round_sequencer #(
  parameter int INIT_TIME       = 20,
  parameter int MIN_TIME        = 5,
  parameter int TIME_STEP       = 1,
  parameter int LIVES           = 3,
  parameter int MAX_LEVEL       = 255,
  parameter int FEEDBACK_CYCLES = 25000000
) (
  input logic clk,
  input logic rst,
  game_round_sequencer_if.master bus
);

  localparam int CNT_W = (FEEDBACK_CYCLES > 1) ? $clog2(FEEDBACK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FB_LOAD = CNT_W'(FEEDBACK_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_PLAY, S_FB, S_OVER} state_e;

  state_e           state_q, state_d;
  logic [7:0]       level_q, level_d;
  logic [7:0]       score_q, score_d;
  logic [2:0]       lives_q, lives_d;
  logic             result_ok_q, result_ok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       time_value_q;
  logic [1:0]       disp_q;
  logic             gen_q, load_q;
  logic             start_prev_q, guess_prev_q;
  logic             start_edge, guess_edge;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? v : v + 8'd1;
  endfunction

  function automatic logic [4:0] round_time(input logic [7:0] lvl);
    logic signed [31:0] d;
    if (lvl == 8'd0) return 5'(INIT_TIME);
    d = ($signed(32'(lvl)) - 32'sd1) * TIME_STEP;
    if (d >= INIT_TIME - MIN_TIME) return 5'(MIN_TIME);
    return 5'(INIT_TIME - d);
  endfunction

  function automatic logic [1:0] disp_code(input state_e s);
    case (s)
      S_GEN, S_PLAY: return 2'b01;
      S_FB:          return 2'b10;
      S_OVER:        return 2'b11;
      default:       return 2'b00;
    endcase
  endfunction

  // Previous-value registers reset to 1 so a button held through reset never fires.
  assign start_edge = bus.start_btn & ~start_prev_q;
  assign guess_edge = bus.guess_btn & ~guess_prev_q;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    score_d     = score_q;
    lives_d     = lives_q;
    result_ok_d = result_ok_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          level_d = 8'd1;
          score_d = 8'd0;
          lives_d = 3'(LIVES);
          state_d = S_GEN;
        end
      end
      S_GEN: state_d = S_PLAY;
      S_PLAY: begin
        // A guess in the same cycle as the timeout takes priority.
        if (guess_edge) begin
          result_ok_d = bus.match;
          cnt_d       = FB_LOAD;
          state_d     = S_FB;
        end else if (bus.timer_end) begin
          result_ok_d = 1'b0;
          cnt_d       = FB_LOAD;
          state_d     = S_FB;
        end
      end
      S_FB: begin
        if (cnt_q == '0) begin
          if (result_ok_q) begin
            score_d = sat_inc8(score_q, 8'hFF);
            level_d = sat_inc8(level_q, 8'(MAX_LEVEL));
            state_d = S_GEN;
          end else begin
            lives_d = lives_q - 3'd1;
            state_d = (lives_q == 3'd1) ? S_OVER : S_GEN;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      level_q      <= 8'd0;
      score_q      <= 8'd0;
      lives_q      <= 3'd0;
      result_ok_q  <= 1'b0;
      cnt_q        <= '0;
      time_value_q <= 5'(INIT_TIME);
      disp_q       <= 2'b00;
      gen_q        <= 1'b0;
      load_q       <= 1'b0;
      start_prev_q <= 1'b1;
      guess_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      result_ok_q  <= result_ok_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_code(state_d);
      gen_q        <= (state_d == S_GEN);
      load_q       <= (state_d == S_GEN);
      start_prev_q <= bus.start_btn;
      guess_prev_q <= bus.guess_btn;
      if (level_d != level_q) time_value_q <= round_time(level_d);
    end
  end

  assign bus.gen_enable = gen_q;
  assign bus.time_load  = load_q;
  assign bus.time_value = time_value_q;
  assign bus.state      = disp_q;
  assign bus.result_ok  = result_ok_q;
  assign bus.level      = level_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer: scripted rounds from a table, corner-case
// sequences, and random games scored by a round-level game model.
module tb_game_round_sequencer;
  localparam int FB     = 4;
  localparam int INIT_T = 20;
  localparam int MIN_T  = 5;
  localparam int STEP   = 1;
  localparam int NLIVES = 3;
  localparam int MAXL   = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_score, m_level, m_lives;

  game_round_sequencer_if bus();

  game_round_sequencer #(
    .INIT_TIME(INIT_T), .MIN_TIME(MIN_T), .TIME_STEP(STEP),
    .LIVES(NLIVES), .MAX_LEVEL(MAXL), .FEEDBACK_CYCLES(FB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // kind: 0 = guess only, 1 = timeout only, 2 = guess and timeout together
  typedef struct {
    int kind;
    bit m;
    bit e_ok;
    int e_score;
    int e_level;
    int e_lives;
    int e_time;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_time(input int lvl);
    int d;
    d = (lvl - 1) * STEP;
    return (d >= INIT_T - MIN_T) ? MIN_T : INIT_T - d;
  endfunction

  task automatic start_game();
    bus.start_btn = 1'b0;
    step();
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
    chk("start_gen", bus.gen_enable, 1);
    chk("start_load", bus.time_load, 1);
    chk("start_state", bus.state, 1);
    chk("start_level", bus.level, 1);
    chk("start_score", bus.score, 0);
    chk("start_lives", bus.lives, NLIVES);
    chk("start_time", bus.time_value, INIT_T);
    step();
    chk("play_gen", bus.gen_enable, 0);
    chk("play_load", bus.time_load, 0);
    chk("play_state", bus.state, 1);
    m_score = 0;
    m_level = 1;
    m_lives = NLIVES;
  endtask

  // Plays one round from PLAY and checks feedback length and the next round setup.
  task automatic do_round(input int kind, input bit m, input bit e_ok,
                          input int e_score, input int e_level, input int e_lives, input int e_time);
    repeat ($urandom_range(0, 2)) step();
    chk("pre_state", bus.state, 1);
    bus.match     = m;
    bus.guess_btn = (kind != 1);
    bus.timer_end = (kind != 0);
    step();
    bus.guess_btn = 1'b0;
    bus.timer_end = 1'b0;
    bus.match     = 1'($urandom_range(0, 1));
    chk("fb_state", bus.state, 2);
    chk("fb_ok", bus.result_ok, e_ok);
    for (int i = 0; i < FB - 1; i++) begin
      bus.timer_end = 1'($urandom_range(0, 1));
      bus.guess_btn = 1'($urandom_range(0, 1));
      bus.start_btn = 1'($urandom_range(0, 1));
      step();
      chk("fb_hold", bus.state, 2);
    end
    bus.timer_end = 1'b0;
    bus.guess_btn = 1'b0;
    bus.start_btn = 1'b0;
    step();
    chk("nx_score", bus.score, e_score);
    chk("nx_level", bus.level, e_level);
    chk("nx_lives", bus.lives, e_lives);
    if (e_lives == 0) begin
      chk("over_state", bus.state, 3);
      for (int i = 0; i < 4; i++) begin
        bus.timer_end = 1'($urandom_range(0, 1));
        step();
        chk("over_gen", bus.gen_enable, 0);
        chk("over_hold", bus.state, 3);
      end
      bus.timer_end = 1'b0;
      chk("over_score", bus.score, e_score);
      chk("over_level", bus.level, e_level);
    end else begin
      chk("nx_state", bus.state, 1);
      chk("nx_gen", bus.gen_enable, 1);
      chk("nx_load", bus.time_load, 1);
      chk("nx_time", bus.time_value, e_time);
      step();
      chk("nx_gen_off", bus.gen_enable, 0);
    end
  endtask

  task automatic model_round(input int kind, input bit m);
    bit ok;
    ok = (kind == 1) ? 1'b0 : m;
    if (ok) begin
      if (m_score < 255) m_score++;
      if (m_level < MAXL) m_level++;
    end else begin
      m_lives--;
    end
    do_round(kind, m, ok, m_score, m_level, m_lives, exp_time(m_level));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1'b1, 1'b1, 1, 2, 3, 19};
    tbl[1] = '{2, 1'b1, 1'b1, 2, 3, 3, 18};
    tbl[2] = '{0, 1'b0, 1'b0, 2, 3, 2, 18};
    tbl[3] = '{1, 1'b1, 1'b0, 2, 3, 1, 18};
    tbl[4] = '{2, 1'b0, 1'b0, 2, 3, 0, 0};

    bus.start_btn = 1'b1;
    bus.guess_btn = 1'b0;
    bus.match     = 1'b0;
    bus.timer_end = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_state", bus.state, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_lives", bus.lives, 0);
    chk("rst_gen", bus.gen_enable, 0);
    chk("rst_load", bus.time_load, 0);
    chk("rst_ok", bus.result_ok, 0);
    chk("rst_time", bus.time_value, INIT_T);
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("held_start_gen", bus.gen_enable, 0);
      chk("held_start_state", bus.state, 0);
    end

    start_game();
    for (int i = 0; i < 5; i++)
      do_round(tbl[i].kind, tbl[i].m, tbl[i].e_ok, tbl[i].e_score,
               tbl[i].e_level, tbl[i].e_lives, tbl[i].e_time);

    start_game();
    for (int i = 0; i < 3; i++)
      do_round(1, 1'b1, 1'b0, 0, 1, 2 - i, INIT_T);
    start_game();

    for (int i = 0; i < 15; i++) model_round(0, 1'b1);
    chk("time_l16", bus.time_value, 5);
    model_round(0, 1'b1);
    chk("level_l17", bus.level, 17);
    chk("time_l17", bus.time_value, 5);

    bus.match = 1'b1;
    bus.guess_btn = 1'b1;
    step();
    bus.guess_btn = 1'b0;
    step();
    chk("fb2_state", bus.state, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midfb_state", bus.state, 0);
    chk("midfb_level", bus.level, 0);
    chk("midfb_score", bus.score, 0);
    chk("midfb_lives", bus.lives, 0);
    chk("midfb_time", bus.time_value, INIT_T);
    bus.guess_btn = 1'b1;
    step();
    bus.guess_btn = 1'b0;
    step();
    chk("idle_guess_state", bus.state, 0);
    chk("idle_guess_gen", bus.gen_enable, 0);
    chk("idle_guess_ok", bus.result_ok, 0);

    for (int g = 0; g < 4; g++) begin
      start_game();
      for (int r = 0; r < 30 && m_lives > 0; r++)
        model_round($urandom_range(0, 2), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
